// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with input synchroniser, mid-bit sampling, false-start
// rejection, framing-error/break recovery and an acknowledged holding register.
module uart_rx_framed #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Serial,
  input  logic       Rx_Ack,
  output logic [7:0] Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Valid,
  output logic       o_Rx_Overrun,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int unsigned HALF       = (CLKS_PER_BIT - 1) / 2;
  // The count starts at 0 on the edge after t0, so the sample edge sees HALF-1.
  localparam logic [15:0] START_LAST = 16'(HALF - 1);
  localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    CLEANUP    = 3'd4,
    BREAK_WAIT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rx_sync_q;
  logic [15:0] count_q, count_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        err_q, err_d;
  logic        active_q, active_d;

  // State and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sync1_q   <= Rx_Serial;
      rx_sync_q <= sync1_q;
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      active_q  <= active_d;
    end
  end

  // Next-state and bit-timing logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        count_d   = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) state_d = START_BIT;
      end
      START_BIT: begin
        if (count_q == START_LAST) begin
          count_d = '0;
          state_d = rx_sync_q ? IDLE : DATA_BITS;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      DATA_BITS: begin
        if (count_q == BIT_LAST) begin
          count_d            = '0;
          shift_d[bit_idx_q] = rx_sync_q;
          if (bit_idx_q == 3'd7) state_d = STOP_BIT;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      STOP_BIT: begin
        if (count_q == BIT_LAST) begin
          count_d = '0;
          state_d = rx_sync_q ? CLEANUP : BREAK_WAIT;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      BREAK_WAIT: begin
        count_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Output / holding-register logic
  always_comb begin
    byte_d    = byte_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (Rx_Ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A load in the same cycle as an ack wins; overrun only on an unacked full buffer.
    if (state_q == CLEANUP) begin
      byte_d  = shift_q;
      dv_d    = 1'b1;
      valid_d = 1'b1;
      if (valid_q && !Rx_Ack) overrun_d = 1'b1;
    end
    if (state_q == STOP_BIT && state_d == BREAK_WAIT) err_d = 1'b1;
    active_d = (state_d != IDLE);
  end

  assign Rx_Byte        = byte_q;
  assign o_Rx_DV        = dv_q;
  assign o_Rx_Valid     = valid_q;
  assign o_Rx_Overrun   = overrun_q;
  assign o_Rx_Frame_Err = err_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: directed frames push expected bytes,
// a negedge monitor pops and compares on every o_Rx_DV.
module tb_uart_rx_framed;

  localparam int unsigned CPB = 87;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx_Serial;
  logic       Rx_Ack;
  logic [7:0] Rx_Byte;
  logic       o_Rx_DV, o_Rx_Valid, o_Rx_Overrun, o_Rx_Frame_Err, o_Rx_Active;

  uart_rx_framed #(.CLKS_PER_BIT(CPB)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx_Serial      (Rx_Serial),
    .Rx_Ack         (Rx_Ack),
    .Rx_Byte        (Rx_Byte),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Valid     (o_Rx_Valid),
    .o_Rx_Overrun   (o_Rx_Overrun),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Active    (o_Rx_Active)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int dv_cyc = 0;
  int start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DV pops one expected byte
  always @(negedge Clk) begin
    if (!Rst) begin
      if (o_Rx_DV) begin
        dv_cnt++;
        dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("dv_unexpected", int'(Rx_Byte), -1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rx_byte", int'(Rx_Byte), int'(e));
        end
      end
      if (o_Rx_Frame_Err) err_cnt++;
    end
  end

  task automatic hold(input logic v, input int unsigned n);
    Rx_Serial = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    hold(1'b0, CPB);
    for (int unsigned i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop) exp_q.push_back(b);
    hold(stop, CPB);
  endtask

  task automatic ack();
    Rx_Ack = 1'b1;
    @(negedge Clk);
    Rx_Ack = 1'b0;
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte"},    int'(Rx_Byte), 0);
    check({tag, "_dv"},      int'(o_Rx_DV), 0);
    check({tag, "_valid"},   int'(o_Rx_Valid), 0);
    check({tag, "_overrun"}, int'(o_Rx_Overrun), 0);
    check({tag, "_ferr"},    int'(o_Rx_Frame_Err), 0);
    check({tag, "_active"},  int'(o_Rx_Active), 0);
  endtask

  initial begin
    int d0, e0;
    logic [7:0] b96;
    Rst       = 1'b1;
    Rx_Serial = 1'b1;
    Rx_Ack    = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    // Single frame, timing of DV relative to the falling edge
    send(8'hA5, 1'b1);
    hold(1'b1, 20);
    check("dv_latency", dv_cyc - start_cyc, 830);
    check("a5_valid", int'(o_Rx_Valid), 1);
    check("a5_ferr_cnt", err_cnt, 0);
    check("a5_active", int'(o_Rx_Active), 0);
    check("a5_dv_cnt", dv_cnt, 1);
    ack();
    check("ack_clears_valid", int'(o_Rx_Valid), 0);

    // Ack between frames: no overrun
    send(8'h3C, 1'b1);
    hold(1'b1, 20);
    ack();
    send(8'hC3, 1'b1);
    hold(1'b1, 20);
    check("c3_byte", int'(Rx_Byte), 8'hC3);
    check("c3_overrun", int'(o_Rx_Overrun), 0);
    check("c3_valid", int'(o_Rx_Valid), 1);
    check("c3_dv_cnt", dv_cnt, 3);
    ack();

    // Back-to-back frames without ack: overrun
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    hold(1'b1, 20);
    check("ovr_set", int'(o_Rx_Overrun), 1);
    check("ovr_byte", int'(Rx_Byte), 8'h22);
    check("ovr_valid", int'(o_Rx_Valid), 1);
    ack();
    check("ovr_ack_valid", int'(o_Rx_Valid), 0);
    check("ovr_ack_overrun", int'(o_Rx_Overrun), 0);

    // Short low glitch is rejected as a false start
    d0 = dv_cnt;
    e0 = err_cnt;
    hold(1'b0, 20);
    hold(1'b1, 100);
    check("glitch_dv", dv_cnt, d0);
    check("glitch_ferr", err_cnt, e0);
    check("glitch_active", int'(o_Rx_Active), 0);
    send(8'h5A, 1'b1);
    hold(1'b1, 20);
    check("5a_dv_cnt", dv_cnt, d0 + 1);
    ack();

    // Bad stop bit then a long break: exactly one error, byte untouched
    e0 = err_cnt;
    send(8'hFF, 1'b0);
    hold(1'b0, 500);
    hold(1'b1, 50);
    check("break_ferr_cnt", err_cnt, e0 + 1);
    check("break_byte", int'(Rx_Byte), 8'h5A);
    check("break_valid", int'(o_Rx_Valid), 0);
    check("break_active", int'(o_Rx_Active), 0);
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    check("81_byte", int'(Rx_Byte), 8'h81);
    check("81_ferr_cnt", err_cnt, e0 + 1);

    // Reset in data bit 4 aborts the frame
    d0  = dv_cnt;
    e0  = err_cnt;
    b96 = 8'h96;
    hold(1'b0, CPB);
    for (int unsigned i = 0; i < 4; i++) hold(b96[i], CPB);
    Rx_Serial = b96[4];
    repeat (40) @(negedge Clk);
    check("pre_rst_active", int'(o_Rx_Active), 1);
    check("pre_rst_valid", int'(o_Rx_Valid), 1);
    #2;
    Rst       = 1'b1;
    Rx_Serial = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    hold(1'b1, 1000);
    check("post_rst_dv", dv_cnt, d0);
    check("post_rst_ferr", err_cnt, e0);
    check("post_rst_active", int'(o_Rx_Active), 0);
    send(8'h96, 1'b1);
    hold(1'b1, 20);
    check("96_byte", int'(Rx_Byte), 8'h96);
    check("96_dv_cnt", dv_cnt, d0 + 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
- UART receiver: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
- Counterpart of the team's uart_tx; sits on the host-facing serial input of the bitmap pipeline and delivers received bytes to the image loader.
- Adds on top of basic reception:
  - input synchronisation;
  - mid-bit sampling with false-start rejection;
  - framing-error detection with break recovery;
  - a one-byte holding register with ack-based overrun flagging.

Parameters:
- CLKS_PER_BIT, 87: Clk frequency / baud rate. Legal range 4..65535.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Rx_Serial  input  1  raw serial line, asynchronous to Clk, idle high.
- Rx_Ack  input  1  consumer has taken Rx_Byte. Sampled each cycle.
- Rx_Byte  output  8  last correctly framed byte. Holds until the next good byte.
- o_Rx_DV  output  1  one-cycle pulse when a new good byte is loaded into Rx_Byte.
- o_Rx_Valid  output  1  level; set with o_Rx_DV, cleared by Rx_Ack.
- o_Rx_Overrun  output  1  sticky; set when a good byte arrives while o_Rx_Valid=1. Cleared by Rx_Ack.
- o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit samples 0.
- o_Rx_Active  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset values (Rst high, immediately, asynchronous):
  - state = IDLE; counters = 0.
  - Both synchroniser flops = 1.
  - Rx_Byte = 0x00.
  - o_Rx_DV, o_Rx_Valid, o_Rx_Overrun, o_Rx_Frame_Err, o_Rx_Active all = 0.
- Reset mid-frame aborts the frame. No DV or error pulse is produced. Reception resumes on the next falling edge after reset release.
- Input path: 2-flop synchroniser; all decisions use the second flop, Rx_Sync.
- HALF = (CLKS_PER_BIT-1)/2, integer division (43 at the default).
- Clock_Count is 16 bits wide.
- Timing reference: t0 is the first rising edge at which IDLE sees Rx_Sync=0.
- IDLE:
  - Clock_Count=0, Bit_Index=0.
  - On Rx_Sync=0 -> START_BIT, o_Rx_Active=1.
- START_BIT:
  - Count to HALF, then sample Rx_Sync (edge t0+HALF).
  - Sample 0 -> DATA_BITS, count reset.
  - Sample 1 -> false start: IDLE, o_Rx_Active=0. No output pulses.
- DATA_BITS:
  - Bit i (i=0..7) is sampled at t0+HALF+(i+1)*CLKS_PER_BIT into shift register bit i.
  - Count runs 0..CLKS_PER_BIT-1 and wraps to 0 at each sample.
  - After bit 7 -> STOP_BIT.
- STOP_BIT: sample at t0+HALF+9*CLKS_PER_BIT.
  - Sample 1 -> CLEANUP with good=1.
  - Sample 0 -> o_Rx_Frame_Err pulses on the next edge; Rx_Byte is unchanged; go to BREAK_WAIT.
- CLEANUP (one cycle), when good=1:
  - Rx_Byte <= shift register.
  - o_Rx_DV=1 for exactly this one cycle.
  - o_Rx_Valid <= 1.
  - If o_Rx_Valid was already 1 and Rx_Ack=0 this cycle, o_Rx_Overrun <= 1; the old byte is overwritten.
  - Then -> IDLE, o_Rx_Active=0.
- BREAK_WAIT:
  - Remain until Rx_Sync=1, then -> IDLE, o_Rx_Active=0.
  - A line held low indefinitely produces exactly one o_Rx_Frame_Err pulse.
- Rx_Ack:
  - Clears o_Rx_Valid and o_Rx_Overrun on the next edge.
  - Rx_Ack in the same cycle as CLKS_PER_BIT CLEANUP load: the load wins. o_Rx_Valid ends at 1; overrun is not set.
  - Rx_Ack while o_Rx_Valid=0 has no effect.
- Back-to-back frames:
  - A start edge in the cycle immediately after CLEANUP (IDLE) must be accepted.
  - No minimum idle time beyond the stop bit is required.
- Any illegal state encoding -> IDLE.

Test Plan:
- Default parameter; send 0xA5 with the correct frame, no ack -> o_Rx_DV pulses once at t0+HALF+9*87+1. Rx_Byte=0xA5, o_Rx_Valid=1, o_Rx_Frame_Err=0, o_Rx_Active low afterwards.
- Send 0x3C, pulse Rx_Ack, then send 0xC3 -> two DV pulses. Rx_Byte ends at 0xC3, o_Rx_Overrun=0, o_Rx_Valid=1.
- Send 0x11 then 0x22 with no ack -> o_Rx_Overrun=1 after the second CLEANUP. Rx_Byte=0x22. A later Rx_Ack clears both o_Rx_Valid and o_Rx_Overrun.
- Low glitch of 20 clocks on the line (shorter than HALF) -> no DV, no error pulse. The state returns to IDLE, then a following 0x5A frame is received correctly.
- Frame 0xFF with the stop bit driven 0, then the line held low for 500 clocks, then released and 0x81 sent -> exactly one o_Rx_Frame_Err pulse; Rx_Byte unchanged; then 0x81 is received with DV.
- Assert Rst during data bit 4 of a frame -> all outputs 0 asynchronously. No DV after release; the next full frame 0x96 is received correctly.
